cpu_control_unit: RTL and testbench
===================================

Name: cpu_control_unit

Overview:
Multi-cycle control unit for the 8-bit CPU datapath. It fetches 32-bit instructions over a request/valid handshake and decodes them. It then drives the datapath controls: the immediate-select mux, the negate select that routes the operand through two's-complement for SUB, the ALU function, the register addresses and the register write enable. State advances on posedge CLK. Control outputs are therefore stable before the datapath muxes sample on the following negedge CLK.

Parameters:
PC_WIDTH, 8, program counter and instruction address width
INSTR_WIDTH, 32, instruction width; fixed fields OP[31:24], DEST[23:16], SRC1[15:8], SRC2/IMM[7:0]

Ports:
CLK  input  1  system clock; all state changes on posedge
RESET  input  1  asynchronous, active-high reset
START  input  1  begin execution from PC=0 when in IDLE
IMEM_REQ  output  1  instruction fetch request
IMEM_ADDR  output  PC_WIDTH  fetch address; equals PC
IMEM_VALID  input  1  instruction data valid
IMEM_DATA  input  INSTR_WIDTH  instruction word
ALU_SEL  output  3  000 forward, 001 add, 010 and, 011 or
IMM_SEL  output  1  1 = operand 2 taken from IMMEDIATE
NEG_SEL  output  1  1 = operand 2 passed through two's complement
DEST_ADDR  output  3  destination register (DEST[2:0])
SRC1_ADDR  output  3  source register 1 (SRC1[2:0])
SRC2_ADDR  output  3  source register 2 (SRC2[2:0])
IMMEDIATE  output  8  IMM field
REG_WRITE_EN  output  1  register file write strobe
BUSY  output  1  high in any state except IDLE and HALT
HALTED  output  1  high in HALT
ILLEGAL  output  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset (asynchronous, active-high; effect is immediate, not clock-aligned): state=IDLE, PC=0, all outputs 0, instruction register cleared. Reset during any state aborts it; IMEM_REQ drops without waiting for a clock.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- IDLE: outputs 0. START=1 at posedge moves to FETCH.
- FETCH: IMEM_REQ=1 and IMEM_ADDR=PC, held for as long as IMEM_VALID=0 (unbounded wait).
  - At the posedge with IMEM_VALID=1: latch IMEM_DATA and go to DECODE; IMEM_REQ=0 from that edge.
  - IMEM_VALID outside FETCH is ignored.
- DECODE: register the fields and control outputs; go to EXECUTE.
- Opcode decode (ALU_SEL / IMM_SEL / NEG_SEL / write):
  - 0x00 loadi: 000 / 1 / 0 / write
  - 0x01 mov: 000 / 0 / 0 / write
  - 0x02 add: 001 / 0 / 0 / write
  - 0x03 sub: 001 / 0 / 1 / write
  - 0x04 and: 010 / 0 / 0 / write
  - 0x05 or: 011 / 0 / 0 / write
  - 0xFF halt: go to HALT after DECODE
  - any other opcode: illegal; controls 0, no write
- EXECUTE: controls held for one cycle; ILLEGAL=1 in this cycle for an illegal opcode only; go to WRITEBACK.
- WRITEBACK: controls still held; REG_WRITE_EN=1 for exactly this cycle, legal opcodes only. PC<=PC+1 modulo 2^PC_WIDTH (0xFF wraps to 0x00); go to FETCH.
- Control outputs retain their values through the next FETCH; only REG_WRITE_EN and ILLEGAL are pulses.
- HALT: HALTED=1, BUSY=0, IMEM_REQ=0, PC frozen, START ignored. Only RESET exits.
- Instruction latency: fetch wait + 4 cycles (FETCH accept, DECODE, EXECUTE, WRITEBACK). With zero-wait memory, next IMEM_REQ rises 4 cycles after the previous one.
- START asserted while BUSY has no effect.

Test Plan:
- Reset then START with zero-wait memory, instr 0x00_02_00_2A (loadi r2,42) -> DECODE: IMM_SEL=1, IMMEDIATE=0x2A, DEST_ADDR=2; WRITEBACK: REG_WRITE_EN pulses 1 cycle; next IMEM_ADDR=1.
- sub 0x03_01_02_03 -> ALU_SEL=001, NEG_SEL=1, IMM_SEL=0, SRC1_ADDR=2, SRC2_ADDR=3, DEST_ADDR=1, one write strobe.
- IMEM_VALID held low 5 cycles in FETCH -> IMEM_REQ stays high with IMEM_ADDR stable; accepted on the 6th cycle; the stray IMEM_VALID pulse in EXECUTE is ignored.
- Opcode 0x7E -> ILLEGAL pulses once in EXECUTE, REG_WRITE_EN never asserts, PC advances by 1.
- Run to PC=0xFF with a legal op -> next fetch IMEM_ADDR=0x00; then opcode 0xFF -> HALTED=1, BUSY=0, no further IMEM_REQ, START ignored.
- RESET asserted mid-FETCH, between clock edges -> IMEM_REQ and all outputs 0 immediately; after release, START refetches from address 0.

Source files
------------

// File: rtl/cpu_control_unit_if.sv
// Instruction-memory fetch bus between the control unit (master) and the
// instruction memory (slave): request/address out, valid/data back.
interface cpu_control_unit_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_valid;
  logic [INSTR_WIDTH-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_data
  );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle control unit for the 8-bit CPU: fetch over a req/valid bus,
// decode, then hold datapath controls through EXECUTE and WRITEBACK.
module cpu_control_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  cpu_control_unit_if.master imem,
  output logic [2:0]         alu_sel_o,
  output logic               imm_sel_o,
  output logic               neg_sel_o,
  output logic [2:0]         dest_addr_o,
  output logic [2:0]         src1_addr_o,
  output logic [2:0]         src2_addr_o,
  output logic [7:0]         immediate_o,
  output logic               reg_write_en_o,
  output logic               busy_o,
  output logic               halted_o,
  output logic               illegal_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_t;

  state_t                 state_q;
  logic [PC_WIDTH-1:0]    pc_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [2:0]             alu_sel_q;
  logic                   imm_sel_q;
  logic                   neg_sel_q;
  logic [2:0]             dest_addr_q;
  logic [2:0]             src1_addr_q;
  logic [2:0]             src2_addr_q;
  logic [7:0]             immediate_q;
  logic                   write_ok_q;
  logic                   reg_write_en_q;
  logic                   illegal_q;

  logic [7:0] opcode;
  logic [2:0] alu_sel_d;
  logic       imm_sel_d;
  logic       neg_sel_d;
  logic       write_ok_d;
  logic       halt_d;
  logic       illegal_d;

  assign opcode = instr_q[31:24];

  always_comb begin
    alu_sel_d  = 3'b000;
    imm_sel_d  = 1'b0;
    neg_sel_d  = 1'b0;
    write_ok_d = 1'b1;
    halt_d     = 1'b0;
    illegal_d  = 1'b0;
    case (opcode)
      8'h00: imm_sel_d = 1'b1;
      8'h01: alu_sel_d = 3'b000;
      8'h02: alu_sel_d = 3'b001;
      8'h03: begin
        alu_sel_d = 3'b001;
        neg_sel_d = 1'b1;
      end
      8'h04: alu_sel_d = 3'b010;
      8'h05: alu_sel_d = 3'b011;
      8'hFF: begin
        halt_d     = 1'b1;
        write_ok_d = 1'b0;
      end
      default: begin
        illegal_d  = 1'b1;
        write_ok_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      pc_q           <= '0;
      instr_q        <= '0;
      alu_sel_q      <= 3'b000;
      imm_sel_q      <= 1'b0;
      neg_sel_q      <= 1'b0;
      dest_addr_q    <= 3'b000;
      src1_addr_q    <= 3'b000;
      src2_addr_q    <= 3'b000;
      immediate_q    <= 8'h00;
      write_ok_q     <= 1'b0;
      reg_write_en_q <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      // Strobes are single-cycle; every other control holds until the next DECODE.
      reg_write_en_q <= 1'b0;
      illegal_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (imem.imem_valid) begin
            instr_q <= imem.imem_data;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          alu_sel_q   <= alu_sel_d;
          imm_sel_q   <= imm_sel_d;
          neg_sel_q   <= neg_sel_d;
          dest_addr_q <= instr_q[18:16];
          src1_addr_q <= instr_q[10:8];
          src2_addr_q <= instr_q[2:0];
          immediate_q <= instr_q[7:0];
          write_ok_q  <= write_ok_d;
          illegal_q   <= illegal_d;
          state_q     <= halt_d ? S_HALT : S_EXECUTE;
        end
        S_EXECUTE: begin
          reg_write_en_q <= write_ok_q;
          state_q        <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          pc_q    <= pc_q + PC_WIDTH'(1);
          state_q <= S_FETCH;
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Only the low three bits of each register field address the 8-entry file.
  logic unused_fields;
  assign unused_fields = ^{instr_q[23:19], instr_q[15:11], instr_q[INSTR_WIDTH-1:32-1] & 1'b0};

  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;

  assign alu_sel_o      = alu_sel_q;
  assign imm_sel_o      = imm_sel_q;
  assign neg_sel_o      = neg_sel_q;
  assign dest_addr_o    = dest_addr_q;
  assign src1_addr_o    = src1_addr_q;
  assign src2_addr_o    = src2_addr_q;
  assign immediate_o    = immediate_q;
  assign reg_write_en_o = reg_write_en_q;
  assign illegal_o      = illegal_q;
  assign busy_o         = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted_o       = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: a scoreboard of expected decode
// results is filled when an instruction is handed over and drained in EXECUTE.
module tb_cpu_control_unit;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       start = 1'b0;
  logic [2:0] alu_sel, dest_addr, src1_addr, src2_addr;
  logic       imm_sel, neg_sel, reg_write_en, busy, halted, illegal;
  logic [7:0] immediate;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_pc = 8'h00;

  typedef struct packed {
    logic [2:0] alu;
    logic       imm;
    logic       neg;
    logic       wr;
    logic       ill;
    logic       halt;
    logic [2:0] dest;
    logic [2:0] src1;
    logic [2:0] src2;
    logic [7:0] imm_v;
  } exp_t;

  exp_t sb_q[$];

  cpu_control_unit_if bus ();

  cpu_control_unit dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .imem           (bus),
    .alu_sel_o      (alu_sel),
    .imm_sel_o      (imm_sel),
    .neg_sel_o      (neg_sel),
    .dest_addr_o    (dest_addr),
    .src1_addr_o    (src1_addr),
    .src2_addr_o    (src2_addr),
    .immediate_o    (immediate),
    .reg_write_en_o (reg_write_en),
    .busy_o         (busy),
    .halted_o       (halted),
    .illegal_o      (illegal)
  );

  always #5 clk = ~clk;

  logic [34:0] all_outs;
  assign all_outs = {bus.imem_req, bus.imem_addr, alu_sel, imm_sel, neg_sel, dest_addr,
                     src1_addr, src2_addr, immediate, reg_write_en, busy, halted, illegal};

  function automatic exp_t expect_of(input logic [31:0] ins);
    exp_t e;
    e       = '0;
    e.dest  = ins[18:16];
    e.src1  = ins[10:8];
    e.src2  = ins[2:0];
    e.imm_v = ins[7:0];
    case (ins[31:24])
      8'h00: begin e.imm = 1'b1; e.wr = 1'b1; end
      8'h01: e.wr = 1'b1;
      8'h02: begin e.alu = 3'b001; e.wr = 1'b1; end
      8'h03: begin e.alu = 3'b001; e.neg = 1'b1; e.wr = 1'b1; end
      8'h04: begin e.alu = 3'b010; e.wr = 1'b1; end
      8'h05: begin e.alu = 3'b011; e.wr = 1'b1; end
      8'hFF: e.halt = 1'b1;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Serves one instruction at exp_pc after wait_cyc stall cycles and checks every phase.
  task automatic run_instr(input logic [31:0] ins, input int wait_cyc, input bit stray,
                           input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL %s req_timeout got=%b required=1", tag, bus.imem_req);
      exp_pc = exp_pc + 8'd1;
      return;
    end
    checks++;
    if (bus.imem_addr !== exp_pc) begin
      errors++;
      $display("FAIL %s fetch_addr got=%h required=%h", tag, bus.imem_addr, exp_pc);
    end
    for (int i = 0; i < wait_cyc; i++) begin
      bus.imem_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, exp_pc}) begin
        errors++;
        $display("FAIL %s wait_hold cyc=%0d got=%b/%h required=1/%h", tag, i,
                 bus.imem_req, bus.imem_addr, exp_pc);
      end
    end
    bus.imem_valid = 1'b1;
    bus.imem_data  = ins;
    @(negedge clk);
    bus.imem_valid = 1'b0;
    bus.imem_data  = $urandom;
    sb_q.push_back(expect_of(ins));
    checks++;
    if ({bus.imem_req, busy} !== 2'b01) begin
      errors++;
      $display("FAIL %s decode_req_busy got=%b%b required=01", tag, bus.imem_req, busy);
    end
    @(negedge clk);
    if (stray) bus.imem_valid = 1'b1;
    e = sb_q.pop_front();
    if (e.halt) begin
      checks++;
      if ({halted, busy, bus.imem_req, illegal} !== 4'b1000) begin
        errors++;
        $display("FAIL %s halt_state got=%b%b%b%b required=1000", tag, halted, busy,
                 bus.imem_req, illegal);
      end
      $display("txn %s pc=%h instr=%h halt", tag, exp_pc, ins);
      return;
    end
    checks++;
    if ({alu_sel, imm_sel, neg_sel, illegal, reg_write_en} !== {e.alu, e.imm, e.neg, e.ill, 1'b0}) begin
      errors++;
      $display("FAIL %s exec_ctrl got=%b_%b_%b_%b_%b required=%b_%b_%b_%b_0", tag, alu_sel,
               imm_sel, neg_sel, illegal, reg_write_en, e.alu, e.imm, e.neg, e.ill);
    end
    if (!e.ill) begin
      checks++;
      if ({dest_addr, src1_addr, src2_addr, immediate} !== {e.dest, e.src1, e.src2, e.imm_v}) begin
        errors++;
        $display("FAIL %s fields got=%0d,%0d,%0d,%h required=%0d,%0d,%0d,%h", tag, dest_addr,
                 src1_addr, src2_addr, immediate, e.dest, e.src1, e.src2, e.imm_v);
      end
    end
    @(negedge clk);
    bus.imem_valid = 1'b0;
    checks++;
    if ({reg_write_en, illegal, alu_sel, imm_sel, neg_sel, busy} !== {e.wr, 1'b0, e.alu, e.imm, e.neg, 1'b1}) begin
      errors++;
      $display("FAIL %s writeback got=%b_%b_%b_%b_%b_%b required=%b_0_%b_%b_%b_1", tag,
               reg_write_en, illegal, alu_sel, imm_sel, neg_sel, busy, e.wr, e.alu, e.imm, e.neg);
    end
    @(negedge clk);
    exp_pc = exp_pc + 8'd1;
    checks++;
    if ({bus.imem_req, bus.imem_addr, reg_write_en, illegal, alu_sel, imm_sel, neg_sel} !==
        {1'b1, exp_pc, 1'b0, 1'b0, e.alu, e.imm, e.neg}) begin
      errors++;
      $display("FAIL %s next_fetch got=%b_%h_%b_%b_%b_%b_%b required=1_%h_0_0_%b_%b_%b", tag,
               bus.imem_req, bus.imem_addr, reg_write_en, illegal, alu_sel, imm_sel, neg_sel,
               exp_pc, e.alu, e.imm, e.neg);
    end
    $display("txn %s instr=%h wait=%0d next_pc=%h", tag, ins, wait_cyc, exp_pc);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (all_outs !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h required=0", all_outs);
    end
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    exp_pc = 8'h00;
    @(negedge clk);
    checks++;
    if (all_outs !== 35'd0) begin
      errors++;
      $display("FAIL idle_outputs got=%h required=0", all_outs);
    end
  endtask

  task automatic test_loadi();
    start_pulse();
    run_instr(32'h00_02_00_2A, 0, 1'b0, "loadi");
  endtask

  task automatic test_sub();
    start = 1'b1;
    run_instr(32'h03_01_02_03, 0, 1'b0, "sub");
    start = 1'b0;
  endtask

  task automatic test_fetch_wait();
    run_instr(32'h02_05_06_07, 5, 1'b1, "add_wait");
  endtask

  task automatic test_back_to_back();
    run_instr(32'h04_03_01_02, 0, 1'b0, "and");
    run_instr(32'h05_07_04_05, 0, 1'b0, "or");
    run_instr(32'h01_06_03_00, 0, 1'b0, "mov");
  endtask

  task automatic test_illegal();
    run_instr(32'h7E_01_02_03, 0, 1'b0, "illegal");
  endtask

  task automatic test_wrap();
    int guard;
    guard = 0;
    while (exp_pc != 8'hFF && guard < 300) begin
      run_instr({8'(guard % 6), 8'($urandom), 8'($urandom), 8'($urandom)}, 0, 1'b0, "fill");
      guard++;
    end
    run_instr(32'h02_01_01_01, 0, 1'b0, "wrap");
    checks++;
    if (bus.imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL wrap_addr got=%h required=00", bus.imem_addr);
    end
  endtask

  task automatic test_halt();
    run_instr(32'h00_01_00_11, 0, 1'b0, "pre_halt");
    run_instr(32'hFF_00_00_00, 0, 1'b0, "halt");
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({halted, busy, bus.imem_req, bus.imem_addr} !== {3'b100, exp_pc}) begin
        errors++;
        $display("FAIL halt_hold cyc=%0d got=%b%b%b_%h required=100_%h", i, halted, busy,
                 bus.imem_req, bus.imem_addr, exp_pc);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    exp_pc = 8'h00;
    start_pulse();
    run_instr(32'h00_04_00_99, 0, 1'b0, "pre_reset");
    checks++;
    if ({bus.imem_req, imm_sel} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_state got=%b%b required=11", bus.imem_req, imm_sel);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (all_outs !== 35'd0) begin
      errors++;
      $display("FAIL async_reset_outputs got=%h required=0", all_outs);
    end
    @(negedge clk);
    rst    = 1'b0;
    exp_pc = 8'h00;
    start_pulse();
    run_instr(32'h05_02_03_04, 0, 1'b0, "refetch");
  endtask

  initial begin
    bus.imem_valid = 1'b0;
    bus.imem_data  = '0;
    test_reset();
    test_loadi();
    test_sub();
    test_fetch_wait();
    test_back_to_back();
    test_illegal();
    test_wrap();
    test_halt();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
